// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI register-access slave controller.
//   state_t          frame sequencing states
//   RW_BIT           position of the read/write flag in the command byte (1 = read)
//   STATUS_BYTE_DEF  default byte returned on MISO while the command byte is shifted in
//   FILL_BYTE        byte returned on MISO during write data bytes
package spi_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RDATA,
        WDATA
    } state_t;

    localparam int unsigned RW_BIT          = 7;
    localparam logic [7:0]  STATUS_BYTE_DEF = 8'hA5;
    localparam logic [7:0]  FILL_BYTE       = 8'h00;

    // MSB-first serial shift-in of one bit.
    function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic bit_in);
        return {cur[6:0], bit_in};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser with edge detection for one asynchronous input.
//   clk       system clock
//   reset     asynchronous active-high reset (chain clears to 0)
//   async_in  asynchronous input pin
//   level     synchronised level
//   rise      1-clk pulse on a synchronised 0->1 transition
//   fall      1-clk pulse on a synchronised 1->0 transition
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_chain <= '0;
            prev       <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
            prev       <= sync_chain[SYNC_STAGES-1];
        end
    end

    assign level = sync_chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_reg_slave_ctrl.sv
// SPI mode-0 slave, oversampled on the system clock, giving addressed burst access to a
// local register bank. Byte 0 is {rw, addr}; following bytes are written to, or read
// from, consecutive addresses starting at addr.
//   clk, reset           system clock, asynchronous active-high reset
//   spi_clk, cs_n, mosi  asynchronous SPI pins from the master
//   miso, miso_oe        serial output (MSB first) and its enable (high during a frame)
//   reg_addr             register address qualified by reg_we / reg_re
//   reg_wdata, reg_we    write data and 1-clk write strobe
//   reg_re, reg_rdata    1-clk read strobe; read data returned one clk later
//   busy                 high whenever a frame is in progress
//   frame_err            1-clk pulse when cs_n rises part way through a byte
module spi_reg_slave_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  STATUS_BYTE = STATUS_BYTE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              frame_err
);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk      (clk),
        .reset    (reset),
        .async_in (spi_clk),
        .level    (sclk_level),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk      (clk),
        .reset    (reset),
        .async_in (cs_n),
        .level    (cs_level),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // mosi shares the synchroniser depth with spi_clk so data and clock stay aligned.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk      (clk),
        .reset    (reset),
        .async_in (mosi),
        .level    (mosi_level),
        .rise     (mosi_rise),
        .fall     (mosi_fall)
    );

    state_t            state;
    logic [2:0]        bit_cnt;
    logic [7:0]        rx_shift;
    logic [7:0]        tx_shift;
    logic [7:0]        tx_buf;
    logic [ADDR_W-1:0] ptr;
    logic              armed;
    logic              rd_pend;
    logic [7:0]        rx_next;
    logic [ADDR_W-1:0] cmd_addr;

    assign rx_next  = shift_in(rx_shift, mosi_level);
    assign cmd_addr = rx_next[ADDR_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            rx_shift  <= 8'h00;
            tx_shift  <= 8'h00;
            tx_buf    <= 8'h00;
            ptr       <= '0;
            armed     <= 1'b0;
            rd_pend   <= 1'b0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= 1'b0;

            // Read data arrives one clk after reg_re; park it for the next byte boundary.
            rd_pend <= reg_re;
            if (rd_pend) begin
                tx_buf <= reg_rdata;
            end

            // A frame already in progress at reset release is ignored until cs_n is seen high.
            if (cs_level) begin
                armed <= 1'b1;
            end

            if (cs_rise) begin
                // End of frame takes priority over any simultaneous spi_clk edge.
                if (bit_cnt != 3'd0) begin
                    frame_err <= 1'b1;
                end
                state   <= IDLE;
                busy    <= 1'b0;
                miso_oe <= 1'b0;
                miso    <= 1'b0;
                bit_cnt <= 3'd0;
            end else if (cs_fall && armed && state == IDLE) begin
                state    <= CMD;
                busy     <= 1'b1;
                miso_oe  <= 1'b1;
                bit_cnt  <= 3'd0;
                tx_shift <= STATUS_BYTE;
                miso     <= STATUS_BYTE[7];
            end else if (state != IDLE) begin
                if (sclk_rise) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        unique case (state)
                            CMD: begin
                                if (rx_next[RW_BIT]) begin
                                    reg_re   <= 1'b1;
                                    reg_addr <= cmd_addr;
                                    ptr      <= cmd_addr + ADDR_W'(1);
                                    state    <= RDATA;
                                end else begin
                                    ptr    <= cmd_addr;
                                    tx_buf <= FILL_BYTE;
                                    state  <= WDATA;
                                end
                            end
                            RDATA: begin
                                // Prefetch for the next byte; the last one of a frame goes unused.
                                reg_re   <= 1'b1;
                                reg_addr <= ptr;
                                ptr      <= ptr + ADDR_W'(1);
                            end
                            WDATA: begin
                                reg_we    <= 1'b1;
                                reg_addr  <= ptr;
                                reg_wdata <= rx_next;
                                ptr       <= ptr + ADDR_W'(1);
                                tx_buf    <= FILL_BYTE;
                            end
                            IDLE: ;
                        endcase
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt == 3'd0) begin
                        tx_shift <= tx_buf;
                        miso     <= tx_buf[7];
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        miso     <= tx_shift[6];
                    end
                end
            end
        end
    end

    logic unused_sig;
    assign unused_sig = ^{sclk_level, mosi_rise, mosi_fall, rx_shift[7], tx_shift[7]};

endmodule

// File: tb/tb_spi_reg_slave_ctrl.sv
module tb_spi_reg_slave_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_clk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       frame_err;

    spi_reg_slave_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .spi_clk   (spi_clk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;  // 100 MHz

    int total = 0;
    int bad   = 0;
    int half  = 100;       // SPI half period: 100 -> 5 MHz, 40 -> 8x oversampling
    int fe_cnt = 0;

    logic [7:0] bank    [128];  // register bank attached to the DUT
    logic [7:0] ref_mem [128];  // expected register contents
    logic [7:0] wtbl    [8];    // data bytes sent by the master after the command

    logic       log_we   [$];
    logic [6:0] log_addr [$];
    logic [7:0] log_data [$];

    // Register bank: 1-clk read latency.
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= bank[reg_addr];
        if (reg_we) bank[reg_addr] <= reg_wdata;
    end

    // Strobe and error monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) fe_cnt++;
            if (reg_we || reg_re) begin
                total++;
                if (reg_we && reg_re) begin
                    bad++;
                    $display("FAIL strobe_exclusive: reg_we=%b reg_re=%b both high", reg_we, reg_re);
                end
                log_we.push_back(reg_we);
                log_addr.push_back(reg_addr);
                log_data.push_back(reg_we ? reg_wdata : 8'h00);
            end
        end
    end

    function automatic logic [17:0] out_vec();
        return {miso, miso_oe, busy, reg_we, reg_re, frame_err, reg_addr, reg_wdata[4:0]} |
               {13'd0, reg_wdata};
    endfunction

    task automatic clear_log();
        log_we.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    // Mode 0 master: drive mosi in the low phase, sample miso just before the rising edge.
    task automatic shift_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            #(half);
            rx = {rx[6:0], miso};
            spi_clk = 1'b1;
            #(half);
            spi_clk = 1'b0;
        end
    endtask

    // One complete frame, checked against the access rules: reads return consecutive
    // addresses from addr (plus one trailing prefetch), writes land at consecutive addresses.
    task automatic run_frame(input logic rw, input logic [6:0] addr, input int ndata,
                             input string name);
        logic [7:0] rx;
        logic [7:0] got [8];
        logic [7:0] exp_b;
        logic [6:0] exp_a;
        int         n_exp;
        int         fe0;
        clear_log();
        fe0 = fe_cnt;
        @(posedge clk);
        #3;
        cs_n = 1'b0;
        shift_bits({rw, addr}, 8, rx);
        got[0] = rx;
        for (int k = 0; k < ndata; k++) begin
            shift_bits(wtbl[k], 8, rx);
            got[k+1] = rx;
        end
        #(half);
        cs_n = 1'b1;
        #(4 * half);

        total++;
        if (got[0] !== 8'hA5) begin
            bad++;
            $display("FAIL %s miso_status: got %h want a5", name, got[0]);
        end
        for (int k = 1; k <= ndata; k++) begin
            exp_a = addr + 7'(k - 1);
            exp_b = rw ? ref_mem[exp_a] : 8'h00;
            total++;
            if (got[k] !== exp_b) begin
                bad++;
                $display("FAIL %s miso_byte%0d: got %h want %h", name, k, got[k], exp_b);
            end
        end
        n_exp = rw ? ndata + 1 : ndata;
        total++;
        if (log_we.size() != n_exp) begin
            bad++;
            $display("FAIL %s strobe_count: got %0d want %0d", name, log_we.size(), n_exp);
        end else begin
            for (int j = 0; j < n_exp; j++) begin
                exp_a = addr + 7'(j);
                total++;
                if (log_we[j] !== !rw || log_addr[j] !== exp_a ||
                    (!rw && log_data[j] !== wtbl[j])) begin
                    bad++;
                    $display("FAIL %s strobe%0d: got we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                             name, j, log_we[j], log_addr[j], log_data[j], !rw, exp_a,
                             rw ? 8'h00 : wtbl[j]);
                end
            end
        end
        if (!rw) begin
            for (int j = 0; j < ndata; j++) ref_mem[addr + 7'(j)] = wtbl[j];
        end
        total++;
        if (fe_cnt != fe0 || busy !== 1'b0 || miso_oe !== 1'b0) begin
            bad++;
            $display("FAIL %s frame_end: got frame_err=%0d busy=%b miso_oe=%b want 0 0 0",
                     name, fe_cnt - fe0, busy, miso_oe);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        cs_n    = 1'b1;
        spi_clk = 1'b0;
        mosi    = 1'b0;
        #1;
        total++;
        if (out_vec() !== 18'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", out_vec());
        end
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        total++;
        if (out_vec() !== 18'd0) begin
            bad++;
            $display("FAIL reset_idle: got %h want 0", out_vec());
        end
    endtask

    task automatic test_write();
        wtbl[0] = 8'h3C;
        wtbl[1] = 8'hC3;
        run_frame(1'b0, 7'h05, 2, "write");
    endtask

    task automatic test_read();
        bank[10] = 8'h11; ref_mem[10] = 8'h11;
        bank[11] = 8'h22; ref_mem[11] = 8'h22;
        bank[12] = 8'h33; ref_mem[12] = 8'h33;
        for (int k = 0; k < 3; k++) wtbl[k] = 8'($urandom);
        run_frame(1'b1, 7'h0A, 3, "read");
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 2; k++) wtbl[k] = 8'($urandom);
        run_frame(1'b1, 7'h7F, 2, "wrap");
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        int fe0;
        clear_log();
        fe0 = fe_cnt;
        @(posedge clk);
        #3;
        cs_n = 1'b0;
        shift_bits({1'b0, 7'($urandom)}, 8, rx);
        shift_bits(8'($urandom), 5, rx);
        #(half);
        cs_n = 1'b1;
        #(4 * half);
        total++;
        if (fe_cnt != fe0 + 1) begin
            bad++;
            $display("FAIL abort_frame_err: got %0d pulses want 1", fe_cnt - fe0);
        end
        total++;
        if (log_we.size() != 0) begin
            bad++;
            $display("FAIL abort_no_strobe: got %0d strobes want 0", log_we.size());
        end
        total++;
        if (miso_oe !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: got miso_oe=%b busy=%b want 0 0", miso_oe, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        int fe0;
        @(posedge clk);
        #3;
        cs_n = 1'b0;
        shift_bits({1'b1, 7'h21}, 8, rx);
        shift_bits(8'($urandom), 3, rx);
        total++;
        if (miso_oe !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midreset_active: got miso_oe=%b busy=%b want 1 1", miso_oe, busy);
        end
        reset = 1'b1;
        #1;
        total++;
        if (out_vec() !== 18'd0) begin
            bad++;
            $display("FAIL midreset_outputs: got %h want 0", out_vec());
        end
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        clear_log();
        fe0 = fe_cnt;
        // cs_n still low from before reset: this traffic must be ignored.
        shift_bits(8'hFF, 8, rx);
        shift_bits(8'($urandom), 8, rx);
        total++;
        if (log_we.size() != 0 || busy !== 1'b0 || miso_oe !== 1'b0) begin
            bad++;
            $display("FAIL midreset_ignored: got strobes=%0d busy=%b miso_oe=%b want 0 0 0",
                     log_we.size(), busy, miso_oe);
        end
        #(half);
        cs_n = 1'b1;
        #(4 * half);
        total++;
        if (fe_cnt != fe0) begin
            bad++;
            $display("FAIL midreset_rearm: got frame_err=%0d want 0", fe_cnt - fe0);
        end
        for (int k = 0; k < 2; k++) wtbl[k] = 8'($urandom);
        run_frame(1'b1, 7'($urandom), 2, "after_reset");
    endtask

    task automatic test_random();
        logic       rw;
        logic [6:0] addr;
        int         n;
        for (int f = 0; f < 6; f++) begin
            rw   = 1'($urandom);
            addr = 7'($urandom);
            n    = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) wtbl[k] = 8'($urandom);
            run_frame(rw, addr, n, "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] addr;
        half = 40;
        addr = 7'($urandom);
        for (int k = 0; k < 3; k++) wtbl[k] = 8'($urandom);
        run_frame(1'b0, addr, 3, "b2b_write");
        for (int k = 0; k < 3; k++) wtbl[k] = 8'($urandom);
        run_frame(1'b1, addr, 3, "b2b_read");
        half = 100;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            bank[i]    = 8'($urandom);
            ref_mem[i] = bank[i];
        end
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the bench itself stalls.
    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
